lcd_scanout: RTL

- Reader side of the LCD framebuffer.
- The PPU writes 2-bit shade indices for a 160x144 frame into an internal dual-port RAM.
- This block reads the RAM in step with vga_controller's DrawX/DrawY, scales the image 2x, and centres it at 320x288 in 640x480.
- It maps shades through a DMG-style palette register to 24-bit RGB, and delays hs/vs/blank so they stay aligned with the pixels.

---
 rtl/de10boy_pkg.sv | 32 +++
 rtl/fb_ram.sv | 33 +++
 rtl/lcd_scanout.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/de10boy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : de10boy_pkg
// Purpose  : Shared LCD geometry, shade/colour types and DMG palette helpers.
// Revision : 1.0 - initial release
// ============================================================================
package de10boy_pkg;

    localparam int LCD_W      = 160;
    localparam int LCD_H      = 144;
    localparam int LCD_PIXELS = 23040;

    typedef logic [1:0]  shade_t;
    typedef logic [23:0] rgb24_t;
    typedef logic [7:0]  pal_t;

    localparam rgb24_t SHADE_RGB [4] = '{24'hE0F8D0, 24'h88C070, 24'h346856, 24'h081820};

    // BGP packs four 2-bit shades; colour index n selects bits [2n+1:2n].
    function automatic shade_t pal_map(input pal_t pal, input shade_t idx);
        shade_t s;
        case (idx)
            2'd0:    s = pal[1:0];
            2'd1:    s = pal[3:2];
            2'd2:    s = pal[5:4];
            default: s = pal[7:6];
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_ram.sv
`default_nettype none
// ============================================================================
// Module   : fb_ram
// Purpose  : 23040x2 simple dual-port framebuffer, registered read, old data
//            returned on a same-address read/write collision.
// Revision : 1.0 - initial release
// ============================================================================
module fb_ram
    import de10boy_pkg::*;
(
    input  logic        clk,
    input  logic        i_we,
    input  logic [14:0] i_waddr,
    input  shade_t      i_wdata,
    input  logic [14:0] i_raddr,
    output shade_t      o_rdata
);

    shade_t mem [LCD_PIXELS];
    shade_t rdata_q;

    // Read and write share one process so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < 15'(LCD_PIXELS))) begin
            mem[i_waddr] <= i_wdata;
        end
        rdata_q <= mem[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/lcd_scanout.sv
`default_nettype none
// ============================================================================
// Module   : lcd_scanout
// Purpose  : 2x-scaled, centred LCD framebuffer scan-out with palette staging
//            and sync/blank delayed to match the 3-cycle pixel pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_scanout
    import de10boy_pkg::*;
#(
    parameter logic [9:0] X_OFF      = 10'd160,
    parameter logic [9:0] Y_OFF      = 10'd96,
    parameter rgb24_t     BORDER_RGB = 24'h404040,
    parameter pal_t       PAL_RESET  = 8'hE4
)(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        fb_we,
    input  logic [14:0] fb_waddr,
    input  logic [1:0]  fb_wdata,
    input  logic        pal_we,
    input  logic [7:0]  pal_in,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_out,
    output logic        frame_start
);

    localparam logic [9:0] X_END = X_OFF + 10'(2 * LCD_W);
    localparam logic [9:0] Y_END = Y_OFF + 10'(2 * LCD_H);

    logic [9:0]  w_gx, w_gy;

    logic [14:0] s0_raddr_d, s0_raddr_q;
    logic        s0_inwin_d, s0_inwin_q;
    logic        s0_blank_d, s0_blank_q;
    logic        s0_hs_d, s0_hs_q;
    logic        s0_vs_d, s0_vs_q;
    logic        s0_origin_d, s0_origin_q;

    logic        s1_inwin_d, s1_inwin_q;
    logic        s1_blank_d, s1_blank_q;
    logic        s1_hs_d, s1_hs_q;
    logic        s1_vs_d, s1_vs_q;
    logic        s1_origin_d, s1_origin_q;

    rgb24_t      rgb_d, rgb_q;
    logic        blank_out_d, blank_out_q;
    logic        hs_out_d, hs_out_q;
    logic        vs_out_d, vs_out_q;
    logic        frame_start_d, frame_start_q;

    pal_t        pal_active_d, pal_active_q;
    pal_t        pal_pending_d, pal_pending_q;
    logic        pal_valid_d, pal_valid_q;

    shade_t      ram_rdata;

    fb_ram u_fb_ram (
        .clk     (Clk),
        .i_we    (fb_we),
        .i_waddr (fb_waddr),
        .i_wdata (fb_wdata),
        .i_raddr (s0_raddr_q),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        // Stage 0: window test and framebuffer address (gy*160 + gx).
        w_gx        = (DrawX - X_OFF) >> 1;
        w_gy        = (DrawY - Y_OFF) >> 1;
        s0_inwin_d  = (DrawX >= X_OFF) && (DrawX < X_END) &&
                      (DrawY >= Y_OFF) && (DrawY < Y_END);
        s0_raddr_d  = s0_inwin_d ? (({5'b0, w_gy} << 7) + ({5'b0, w_gy} << 5) + {5'b0, w_gx})
                                 : 15'd0;
        s0_blank_d  = blank_in;
        s0_hs_d     = hs_in;
        s0_vs_d     = vs_in;
        s0_origin_d = (DrawX == 10'd0) && (DrawY == 10'd0);

        // Palette only swaps at the frame origin, so a frame never tears.
        pal_pending_d = pal_we ? pal_in : pal_pending_q;
        pal_active_d  = pal_active_q;
        pal_valid_d   = pal_valid_q | pal_we;
        if (s0_origin_d) begin
            if (pal_valid_q || pal_we) begin
                pal_active_d = pal_we ? pal_in : pal_pending_q;
            end
            pal_valid_d = 1'b0;
        end

        // Stage 1: RAM read in flight, carry the flags alongside.
        s1_inwin_d  = s0_inwin_q;
        s1_blank_d  = s0_blank_q;
        s1_hs_d     = s0_hs_q;
        s1_vs_d     = s0_vs_q;
        s1_origin_d = s0_origin_q;

        // Stage 2: colour.
        if (!s1_blank_q) begin
            rgb_d = 24'h000000;
        end else if (!s1_inwin_q) begin
            rgb_d = BORDER_RGB;
        end else begin
            rgb_d = SHADE_RGB[pal_map(pal_active_q, ram_rdata)];
        end
        blank_out_d   = s1_blank_q;
        hs_out_d      = s1_hs_q;
        vs_out_d      = s1_vs_q;
        frame_start_d = s1_origin_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s0_raddr_q    <= 15'd0;
            s0_inwin_q    <= 1'b0;
            s0_blank_q    <= 1'b0;
            s0_hs_q       <= 1'b1;
            s0_vs_q       <= 1'b1;
            s0_origin_q   <= 1'b0;
            s1_inwin_q    <= 1'b0;
            s1_blank_q    <= 1'b0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            s1_origin_q   <= 1'b0;
            rgb_q         <= 24'h000000;
            blank_out_q   <= 1'b0;
            hs_out_q      <= 1'b1;
            vs_out_q      <= 1'b1;
            frame_start_q <= 1'b0;
            pal_active_q  <= PAL_RESET;
            pal_pending_q <= PAL_RESET;
            pal_valid_q   <= 1'b0;
        end else begin
            s0_raddr_q    <= s0_raddr_d;
            s0_inwin_q    <= s0_inwin_d;
            s0_blank_q    <= s0_blank_d;
            s0_hs_q       <= s0_hs_d;
            s0_vs_q       <= s0_vs_d;
            s0_origin_q   <= s0_origin_d;
            s1_inwin_q    <= s1_inwin_d;
            s1_blank_q    <= s1_blank_d;
            s1_hs_q       <= s1_hs_d;
            s1_vs_q       <= s1_vs_d;
            s1_origin_q   <= s1_origin_d;
            rgb_q         <= rgb_d;
            blank_out_q   <= blank_out_d;
            hs_out_q      <= hs_out_d;
            vs_out_q      <= vs_out_d;
            frame_start_q <= frame_start_d;
            pal_active_q  <= pal_active_d;
            pal_pending_q <= pal_pending_d;
            pal_valid_q   <= pal_valid_d;
        end
    end

    assign Red         = rgb_q[23:16];
    assign Green       = rgb_q[15:8];
    assign Blue        = rgb_q[7:0];
    assign hs_out      = hs_out_q;
    assign vs_out      = vs_out_q;
    assign blank_out   = blank_out_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire
